// File: rtl/fast_arith_pkg.sv
// fast_arith_pkg: shared types and width helpers for the FastArithmetic MAC datapath.
package fast_arith_pkg;
  typedef enum logic {ACCUM, DONE} state_t;
  // Helpers work on 64-bit values so each instance can truncate to its own widths.
  function automatic logic [63:0] sext(input logic [63:0] v, input int w);
    return 64'($signed(v << (64 - w)) >>> (64 - w));
  endfunction
  function automatic logic [63:0] sat_max(input int w);
    return (64'(1) << (w - 1)) - 64'(1);
  endfunction
  function automatic logic [63:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/signed_mac_accumulator_sat_adder.sv
// sat_adder: combinational signed adder with overflow flag; SIGNED_MAC_SATURATE_EN clamps on overflow.
module sat_adder import fast_arith_pkg::*; #(
  parameter int W = 24
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);
  localparam logic [W-1:0] SAT_MAX = W'(sat_max(W));
  localparam logic [W-1:0] SAT_MIN = W'(sat_min(W));
  logic [W-1:0] raw;
  assign raw = a + b;
  assign ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
`ifdef SIGNED_MAC_SATURATE_EN
  assign sum = ovf ? (a[W-1] ? SAT_MIN : SAT_MAX) : raw;
`else
  assign sum = raw;
`endif
endmodule

// File: rtl/signed_mac_accumulator.sv
// signed_mac_accumulator: sums BLOCK_LEN signed products per result over valid/ready ports.
// SIGNED_MAC_SATURATE_EN selects saturating instead of wrapping accumulation.
module signed_mac_accumulator import fast_arith_pkg::*; #(
  parameter int INPUT_LENGTH = 16,
  parameter int ACC_LENGTH   = 24,
  parameter int BLOCK_LEN    = 4
) (
  input  logic                    iClk,
  input  logic                    iRstN,
  input  logic [INPUT_LENGTH-1:0] iProd,
  input  logic                    iValid,
  output logic                    oReady,
  input  logic                    iClear,
  output logic [ACC_LENGTH-1:0]   oAcc,
  output logic                    oValid,
  input  logic                    iReady,
  output logic                    oOverflow
);
  localparam int CW = cnt_w(BLOCK_LEN);
  state_t                state;
  logic [ACC_LENGTH-1:0] acc, sum, prod_ext;
  logic [CW-1:0]         cnt;
  logic                  sticky, ovf, last;
  assign prod_ext = ACC_LENGTH'(sext(64'(iProd), INPUT_LENGTH));
  assign oReady   = state == ACCUM;
  assign last     = cnt == CW'(BLOCK_LEN - 1);
  sat_adder #(.W(ACC_LENGTH)) u_add (.a(acc), .b(prod_ext), .sum(sum), .ovf(ovf));
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      sticky    <= 1'b0;
      oAcc      <= '0;
      oValid    <= 1'b0;
      oOverflow <= 1'b0;
    end else if (iClear) begin
      state  <= ACCUM;
      acc    <= '0;
      cnt    <= '0;
      sticky <= 1'b0;
      oValid <= 1'b0;
    end else if (state == ACCUM && iValid) begin
      if (last) begin
        state     <= DONE;
        oAcc      <= sum;
        oOverflow <= sticky | ovf;
        oValid    <= 1'b1;
        acc       <= '0;
        cnt       <= '0;
        sticky    <= 1'b0;
      end else begin
        acc    <= sum;
        cnt    <= cnt + CW'(1);
        sticky <= sticky | ovf;
      end
    end else if (state == DONE && iReady) begin
      state  <= ACCUM;
      oValid <= 1'b0;
    end
  end
endmodule
